// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers on the
// CPU data bus, a small byte FIFO and an LSB-first serialiser with a registered line.
module mmio_uart_tx #(
  parameter logic [31:0] BASE       = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [15:0]     div, baudcnt, baudcnt_n;
  logic [7:0]      shift, shift_n;
  logic [2:0]      bitcnt, bitcnt_n;
  logic            tx_n;
  logic            wr, push_req, wr_status, wr_div;
  logic            pop, push, full, empty, busy;
  logic [3:0]      cnt4;
  logic            unused;

  assign unused = ^{a[1:0], wd[31:16]};

  assign sel       = (a[31:4] == BASE[31:4]);
  assign wr        = we && sel;
  assign push_req  = wr && (a[3:2] == 2'd0);
  assign wr_status = wr && (a[3:2] == 2'd1);
  assign wr_div    = wr && (a[3:2] == 2'd2);

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign cnt4  = 4'(count);

  // The serialiser only takes a byte from IDLE; a push to a full FIFO
  // still lands when that same edge frees a slot.
  assign pop  = (state == IDLE) && !empty;
  assign push = push_req && (!full || pop);

  always_comb begin
    rd = '0;
    if (sel) begin
      case (a[3:2])
        2'd1:    rd = {24'b0, cnt4, ovf, empty, full, busy};
        2'd2:    rd = {16'b0, div};
        default: rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      div   <= DIV_RESET;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (wr_status && wd[3])  ovf <= 1'b0;
      if (wr_div) div <= wd[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bitcnt  <= '0;
      baudcnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bitcnt  <= bitcnt_n;
      baudcnt <= baudcnt_n;
      tx      <= tx_n;
    end
  end

  // Each bit lasts baudcnt+1 clocks; div is only sampled on reload, so a
  // BAUDDIV write never stretches or cuts the bit in flight.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bitcnt_n  = bitcnt;
    baudcnt_n = baudcnt;
    case (state)
      IDLE: begin
        if (pop) begin
          state_n   = START;
          shift_n   = mem[rptr];
          bitcnt_n  = '0;
          baudcnt_n = div;
        end
      end
      START: begin
        if (baudcnt == '0) begin
          baudcnt_n = div;
          state_n   = DATA;
        end else begin
          baudcnt_n = baudcnt - 16'd1;
        end
      end
      DATA: begin
        if (baudcnt == '0) begin
          shift_n   = {1'b0, shift[7:1]};
          bitcnt_n  = bitcnt + 3'd1;
          baudcnt_n = div;
          if (bitcnt == 3'd7) state_n = STOP;
        end else begin
          baudcnt_n = baudcnt - 16'd1;
        end
      end
      STOP: begin
        if (baudcnt == '0) state_n = IDLE;
        else               baudcnt_n = baudcnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // The line register takes the level of the state being entered.
  always_comb begin
    tx_n = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift_n[0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed + randomized bench for mmio_uart_tx: register reads are checked against
// hand-derived values, the tx line against waveforms built from byte lists and bit periods.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic txlog[$];
  logic expq[$];

  mmio_uart_tx #(.BASE(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd4)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;

  // One line sample per clock, taken on the falling edge.
  always @(negedge clk) txlog.push_back(tx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic exp_sel;
    we = 1'b0;
    a  = addr;
    exp_sel = (addr[31:4] == BASE[31:4]);
    #1;
    chk(tag, rd, exp);
    chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
  endtask

  task automatic add_bits(input logic v, input int n);
    repeat (n) expq.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int d);
    add_bits(1'b0, d + 1);
    for (int i = 0; i < 8; i++) add_bits(b[i], d + 1);
    add_bits(1'b1, d + 1);
  endtask

  // Compares the logged line from index st against the expected bit queue.
  task automatic seg_check(input string tag, input int st);
    logic [255:0] o, e;
    o = '0;
    e = '0;
    for (int i = 0; i < expq.size(); i++) begin
      e[i] = expq[i];
      o[i] = (st + i < txlog.size()) ? txlog[st + i] : 1'bx;
    end
    chk_wide(tag, o, e);
    expq.delete();
  endtask

  task automatic chk_wide(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: tx observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_of(input int cnt, input bit ov, input bit bsy);
    return (cnt << 4) | (32'(ov) << 3) | (32'(cnt == 0) << 2) | (32'(cnt == 4) << 1) | 32'(bsy);
  endfunction

  initial begin
    int st, d, n, len, zeros, rst_idx;
    logic [7:0] b;
    logic [7:0] bq[$];

    // Reset state
    #2 reset = 1'b1;
    #1 chk("tx_in_reset", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    rd_check("status_reset", BASE + 4, 32'h04);
    rd_check("div_reset", BASE + 8, 32'd4);
    rd_check("txdata_reads0", BASE, 32'd0);
    chk("tx_idle", 32'(tx), 32'd1);
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    rd_check("reserved_reads0", BASE + 32'hC, 32'd0);
    rd_check("div_after_reserved", BASE + 8, 32'd4);

    // Single frame 0xA5 at div=4
    wr(BASE, 32'h0000_00A5);
    st = txlog.size();
    rd_check("status_queued", BASE + 4, status_of(1, 0, 0));
    tick(1);
    rd_check("status_started", BASE + 4, status_of(0, 0, 1));
    tick(30);
    rd_check("status_midframe", BASE + 4, status_of(0, 0, 1));
    tick(25);
    rd_check("status_after_a5", BASE + 4, 32'h04);
    add_bits(1'b1, 1); add_frame(8'hA5, 4); add_bits(1'b1, 3);
    seg_check("frame_a5", st);

    // Burst of five while the first is transmitting, overflow, clear, push on pop
    wr(BASE, 32'h11);
    st = txlog.size();
    for (int i = 0; i < 4; i++) wr(BASE, 32'h12 + i);
    rd_check("status_full", BASE + 4, status_of(4, 0, 1));
    wr(BASE, 32'h16);
    rd_check("status_ovf", BASE + 4, status_of(4, 1, 1));
    wr(BASE + 4, 32'h8);
    rd_check("status_ovf_clr", BASE + 4, status_of(4, 0, 1));
    tick(45);
    wr(BASE, 32'h17);
    rd_check("status_push_on_pop", BASE + 4, status_of(4, 0, 1));
    tick(280);
    for (int k = 0; k < 6; k++) begin
      b = (k < 5) ? 8'(8'h11 + k) : 8'h17;
      add_bits(1'b1, 1); add_frame(b, 4);
      seg_check($sformatf("burst_frame%0d", k), st + k * 51);
    end
    add_bits(1'b1, 12);
    seg_check("burst_tail", st + 6 * 51);
    rd_check("status_after_burst", BASE + 4, 32'h04);

    // div=0: ten-clock frame
    wr(BASE + 8, 32'd0);
    rd_check("div0_read", BASE + 8, 32'd0);
    wr(BASE, 32'hFF);
    st = txlog.size();
    tick(15);
    add_bits(1'b1, 1); add_frame(8'hFF, 0); add_bits(1'b1, 3);
    seg_check("frame_div0", st);

    // BAUDDIV change in the middle of data bit 1
    wr(BASE + 8, 32'd4);
    b = 8'($urandom);
    wr(BASE, 32'(b));
    st = txlog.size();
    tick(12);
    wr(BASE + 8, 32'd9);
    tick(80);
    add_bits(1'b1, 1); add_bits(1'b0, 5); add_bits(b[0], 5); add_bits(b[1], 5);
    for (int i = 2; i < 8; i++) add_bits(b[i], 10);
    add_bits(1'b1, 10); add_bits(1'b1, 2);
    seg_check("frame_div_change", st);

    // Randomized rounds against the byte-list model
    for (int r = 0; r < 5; r++) begin
      wr(BASE + 32'h10 + 32'($urandom_range(0, 3) * 4), $urandom);
      d = $urandom_range(0, 5);
      wr(BASE + 8, 32'(d));
      rd_check($sformatf("rnd%0d_div", r), BASE + 8, 32'(d));
      n = $urandom_range(1, 5);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      wr(BASE, 32'(bq[0]));
      st = txlog.size();
      for (int i = 1; i < n; i++) wr(BASE, 32'(bq[i]));
      rd_check($sformatf("rnd%0d_status", r), BASE + 4,
               (n == 1) ? status_of(1, 0, 0) : status_of(n - 1, 0, 1));
      len = 10 * (d + 1) + 1;
      tick(n * len + 8);
      for (int k = 0; k < n; k++) begin
        add_bits(1'b1, 1); add_frame(bq[k], d);
        seg_check($sformatf("rnd%0d_frame%0d", r, k), st + k * len);
      end
      add_bits(1'b1, 4);
      seg_check($sformatf("rnd%0d_tail", r), st + n * len);
    end

    // Asynchronous reset during data bit 3 (div=6, bit3 forced low)
    wr(BASE + 8, 32'd6);
    b = 8'($urandom) & 8'hF7;
    wr(BASE, 32'(b));
    st = txlog.size();
    wr(BASE, 32'h5A);
    wr(BASE, 32'hC3);
    tick(28);
    chk("tx_bit3_before_reset", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1 chk("tx_async_reset", 32'(tx), 32'd1);
    rd_check("status_in_reset", BASE + 4, 32'h04);
    @(negedge clk);
    reset = 1'b0;
    rst_idx = txlog.size();
    tick(1);
    rd_check("div_after_reset", BASE + 8, 32'd4);
    tick(150);
    zeros = 0;
    for (int i = rst_idx; i < txlog.size(); i++) if (txlog[i] !== 1'b1) zeros++;
    chk("no_tx_after_reset", 32'(zeros), 32'd0);
    rd_check("status_after_reset", BASE + 4, 32'h04);

    // Out-of-range accesses
    wr(BASE + 32'h10, 32'h55);
    wr(BASE + 32'h18, 32'd0);
    wr(BASE + 32'h14, 32'h0);
    st = txlog.size();
    rd_check("unsel_status_alias", BASE + 32'h14, 32'd0);
    rd_check("unsel_div_alias", BASE + 32'h18, 32'd0);
    tick(1);
    rd_check("status_after_unsel", BASE + 4, 32'h04);
    rd_check("div_after_unsel", BASE + 8, 32'd4);
    tick(20);
    add_bits(1'b1, 20);
    seg_check("idle_after_unsel", st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It sits on the CPU data-memory bus alongside the data RAM, using the same bus signals: we, a, wd, rd.
- A CPU store to its TXDATA register queues a byte in a small FIFO. A serialiser then shifts the byte out on tx as 8N1, LSB first.
- Status and baud-divisor registers are readable by ordinary loads, so software polls before storing.

Parameters:
- BASE, 32'h0000_0100, word-aligned base address; the block decodes a[31:4]==BASE[31:4].
- FIFO_DEPTH, 4, number of byte entries; must be a power of 2, minimum 2.
- DIV_RESET, 16'd4, reset value of BAUDDIV. Bit period is BAUDDIV+1 clocks.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  bus write enable (the CPU's memwrite).
- a  input  32  bus byte address (the CPU's ALU result).
- wd  input  32  bus write data.
- rd  output  32  bus read data; combinational from a and current state.
- sel  output  1  combinational, 1 when a hits this block; external read mux uses it.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Decode: sel = (a[31:4]==BASE[31:4]). Register offset is a[3:2]:
  - 0: TXDATA
  - 1: STATUS
  - 2: BAUDDIV
  - 3: reserved (reads 0, writes ignored)
- Reads are combinational, like the data RAM, with zero cycles latency:
  - TXDATA reads 0.
  - STATUS reads {24'b0, count[3:0], ovf, empty, full, busy}. busy = (state!=IDLE), full = (count==FIFO_DEPTH), empty = (count==0).
  - BAUDDIV reads {16'b0, div}.
  - rd=0 whenever sel=0.
- Writes take effect on the rising edge when we && sel:
  - TXDATA: push wd[7:0]. If full and no pop occurs in the same cycle, the byte is dropped and ovf is set.
  - STATUS: if wd[3]=1, clear ovf. All other bits are read-only.
  - BAUDDIV: div <= wd[15:0].
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit read/write pointers that wrap modulo FIFO_DEPTH, plus a count register.
  - Simultaneous push and pop: both happen and count is unchanged; this holds when full and when count==1.
  - A push to an empty FIFO is visible in count after that edge.
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If count!=0 at an edge, pop the head into the 8-bit shift register, load bitcnt=0 and baudcnt=div, and go to START.
  - START: tx=0. When baudcnt==0, reload baudcnt=div and go to DATA; otherwise decrement baudcnt.
  - DATA: tx=shift[0]. When baudcnt==0: shift right, bitcnt++, reload baudcnt. After bit 7 completes, go to STOP.
  - STOP: tx=1. When baudcnt==0, go to IDLE.
  - There is exactly one IDLE cycle between back-to-back frames.
  - tx is registered and reflects the new state's level in the cycle after the transition edge. A frame is therefore 10*(div+1) clocks plus the one IDLE cycle.
- BAUDDIV written mid-frame: the current bit keeps its period; the new div applies from the next reload.
- div=0 is legal: each bit lasts one clock.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, tx=1, FIFO emptied (pointers and count 0), ovf=0, div=DIV_RESET, shift/bitcnt/baudcnt=0.
  - rd follows from that state, so STATUS reads 0x04.
- Writes with sel=0 have no effect. The data RAM must be gated by !sel externally; that gating is not part of this block.

Test Plan:
- Reset, then read STATUS at BASE+4 -> rd=0x00000004; tx=1; BAUDDIV at BASE+8 reads 4.
- Store 0x000000A5 to BASE, div=4 -> tx low for 5 clocks, then 1,0,1,0,0,1,0,1 at 5 clocks each, then high for 5 clocks. busy=1 throughout, returns to 0 after the frame.
- With tx busy, store 5 bytes 0x11..0x15 back-to-back (FIFO_DEPTH=4, first byte popped at the first IDLE edge):
  - All 5 accepted; count peaks at 4.
  - A 6th store before any further pop -> ovf=1 and the byte is dropped.
  - Store 0x8 to STATUS -> ovf=0.
  - Frames appear in order 0x11..0x15, each separated by exactly 1 idle clock.
- Store 0 to BAUDDIV, then 0xFF to TXDATA -> the whole frame lasts 10 clocks.
- Write BAUDDIV=9 mid-data-bit -> the current bit keeps period 5; subsequent bits last 10 clocks.
- Assert reset during DATA bit 3 -> tx=1 immediately, without waiting for a clock edge; STATUS=0x04; queued bytes are never transmitted.
- Load/store to BASE+0x10 -> sel=0, rd=0, no state change.
